deconv_out_serializer: RTL and testbench
========================================

# deconv_out_serializer

Output stage directly downstream of `deconv2D`. On the rising edge of `deconv2D`'s `done`, it captures the full (N·K)×(N·K) parallel `image_output` array into a local frame buffer. It then streams the frame out one pixel per handshake in raster order over a valid/ready interface, tagging end-of-row and end-of-frame. This frees `deconv2D` to start the next frame while the serializer drains the current one.

## Interface

Parameters:

- `N`, default 2: input image side, matching `deconv2D`.
- `K`, default 3: kernel side, matching `deconv2D`.
- `PIXEL_WIDTH`, default 8: output pixel width.
- `OUT_DIM`, default N*K (derived, not overridden): output frame side.

Ports:

- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0, sampled on posedge clk).
- `done_in`  in  1  `deconv2D` `done`; level signal, rising edge marks frame valid.
- `image_in`  in  PIXEL_WIDTH × [0:OUT_DIM*OUT_DIM-1]  unpacked array, raster order, index = row*OUT_DIM+col.
- `m_valid`  out  1  output pixel valid.
- `m_ready`  in  1  downstream accepts pixel.
- `m_data`  out  PIXEL_WIDTH  current pixel.
- `m_row`, `m_col`  out  $clog2(OUT_DIM)  coordinates of `m_data`.
- `m_eol`  out  1  high with the last pixel of each row.
- `m_last`  out  1  high with the final pixel of the frame.
- `capture_ready`  out  1  high in IDLE; a frame is accepted only in this state.
- `drop_count`  out  8  saturating count of frames lost because `done_in` rose while not in IDLE.

## Operation

- States:
  - IDLE: `capture_ready`=1, `m_valid`=0.
  - STREAM: `m_valid`=1.
- Edge detect: `done_d` is a register of `done_in`. `done_rise` = `done_in & ~done_d`. A level held high for many cycles produces exactly one capture.
- IDLE → STREAM on `done_rise`:
  - All OUT_DIM² entries of `image_in` are copied into the buffer on that edge.
  - `idx`, `row`, `col` are cleared to 0.
- In STREAM, a handshake is `m_valid & m_ready`. On each handshake:
  - `idx`++.
  - `col`++, wrapping to 0 at OUT_DIM-1; `row`++ on that wrap.
- STREAM → IDLE on the handshake where `idx == OUT_DIM²-1`.
- `m_data` = buffer[idx]; `m_row`/`m_col` = row/col.
- `m_eol` = (col == OUT_DIM-1). `m_last` = (idx == OUT_DIM²-1). Both are qualified by `m_valid`, i.e. 0 in IDLE.
- `done_rise` while in STREAM: the frame is not captured, the buffer and stream are unaffected, and `drop_count` increments, saturating at 255.
- `done_rise` in the same cycle as the final handshake: the state is still STREAM, so the frame is dropped and counted. There is no back-to-back capture.
- `image_in` is sampled only on the capture edge. Later changes to `image_in` never affect the streamed data.
- Reset values (`rst`=0):
  - State IDLE, `capture_ready`=1, `done_d`=0.
  - `m_valid`, `m_eol`, `m_last` = 0.
  - `idx`, `row`, `col`, `m_row`, `m_col`, `m_data` = 0.
  - `drop_count`=0.
  - Buffer contents are don't-care.
- Reset mid-STREAM abandons the frame with no `m_last`. If `done_in` is already high when reset releases, `done_d`=0 makes it count as a rise in the first post-reset cycle, so the frame is captured.

## Timing

- Capture latency: `done_in` rise sampled at edge t, so `m_valid`=1 with pixel 0 in the cycle after edge t.
- With `m_ready` held high, throughput is 1 pixel per cycle. A frame occupies exactly OUT_DIM² cycles (36 for defaults), and `capture_ready` returns to 1 the cycle after the `m_last` handshake.
- Backpressure: while `m_valid & ~m_ready`, the values of `m_data`, `m_row`, `m_col`, `m_eol`, `m_last` are held stable. `m_valid` never deasserts mid-frame.
- There is no combinational path from `m_ready` to `m_valid`; `m_ready` only gates register updates.

## Structure

- Shared package `deconv_pkg`:
  - Default `N`, `K`, `PIXEL_WIDTH`, `STRIDE`.
  - Serializer state enum {IDLE, STREAM}.
  - Localparam helpers for OUT_DIM and frame size, also used by `deconv2D`.
- Single module; no sub-module is warranted.
- The buffer is a register array (36×8 bits by default). Output muxing is indexed by `idx`.

## Test plan

- Ramp frame: `image_in[i]`=i, single `done_in` rise, `m_ready`=1 → 36 beats with `m_data`=0..35 on consecutive cycles. `m_eol` on idx 5,11,…,35; `m_last` only on idx 35; `m_row`/`m_col` match idx/6, idx%6.
- Backpressure: the same frame with `m_ready` toggled 1,0,0,1,… → identical data sequence, outputs stable during stalls, no loss or duplication.
- Held done / input change: `done_in` held high for 50 cycles and `image_in` changed to all 8'hFF after capture → exactly one frame, data 0..35, `drop_count`=0.
- Drop: a second `done_in` rise at beat 10 of streaming, and another coinciding with the `m_last` handshake → `drop_count`=2, streamed frame intact.
- Reset mid-frame: `rst`=0 for one cycle at beat 20 → next cycle `m_valid`=0, `capture_ready`=1, `drop_count`=0; a fresh capture then streams from pixel 0.
- Integration: `deconv2D` loaded with image [1 2;3 4] and the 3×3 identity kernel from its bench → first beat `m_data`=1, and the sum of all beats equals the sum of `deconv2D` `image_output`.

Source files
------------

// File: rtl/deconv_pkg.sv
`default_nettype none
// ============================================================================
// Package     : deconv_pkg
// Description : Shared defaults, serializer state encoding and frame geometry
//               helpers for deconv2D and its output serializer.
// Revision    : 1.0 - initial release
// ============================================================================
package deconv_pkg;

  // Default geometry shared with deconv2D
  localparam int DEFAULT_N           = 2;
  localparam int DEFAULT_K           = 3;
  localparam int DEFAULT_PIXEL_WIDTH = 8;
  localparam int DEFAULT_STRIDE      = 3;

  // Serializer state encoding
  typedef enum logic [0:0] {
    SER_IDLE   = 1'b0,
    SER_STREAM = 1'b1
  } ser_state_e;

  // Side of the deconvolved output frame
  function automatic int out_dim(input int n, input int k);
    return n * k;
  endfunction

  // Number of pixels in one output frame
  function automatic int frame_size(input int n, input int k);
    return (n * k) * (n * k);
  endfunction

  // Width of a counter covering 0..d-1, never narrower than one bit
  function automatic int count_width(input int d);
    return (d > 1) ? $clog2(d) : 1;
  endfunction

endpackage : deconv_pkg
`default_nettype wire

// File: rtl/deconv_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : deconv_out_serializer
// Description : Captures a full parallel deconv2D output frame on the rising
//               edge of done_in and streams it out one pixel per valid/ready
//               handshake in raster order, tagging end-of-row / end-of-frame.
//               Frames arriving while a stream is in progress are dropped
//               and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module deconv_out_serializer
  import deconv_pkg::*;
#(
  parameter  int N           = DEFAULT_N,
  parameter  int K           = DEFAULT_K,
  parameter  int PIXEL_WIDTH = DEFAULT_PIXEL_WIDTH,
  localparam int OUT_DIM     = out_dim(N, K),
  localparam int FRAME       = frame_size(N, K),
  localparam int CW          = count_width(OUT_DIM),
  localparam int IW          = count_width(FRAME)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   done_in,
  input  logic [PIXEL_WIDTH-1:0] image_in [0:FRAME-1],
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [PIXEL_WIDTH-1:0] m_data,
  output logic [CW-1:0]          m_row,
  output logic [CW-1:0]          m_col,
  output logic                   m_eol,
  output logic                   m_last,
  output logic                   capture_ready,
  output logic [7:0]             drop_count
);

  localparam logic [IW-1:0] LAST_IDX = IW'(FRAME - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_DIM - 1);
  localparam logic [7:0]    DROP_MAX = 8'hFF;

  ser_state_e             state_q, state_d;
  logic                   done_prev_q, done_prev_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          row_q, row_d;
  logic [CW-1:0]          col_q, col_d;
  logic [7:0]             drop_q, drop_d;
  logic [PIXEL_WIDTH-1:0] frame_q [0:FRAME-1];
  logic [PIXEL_WIDTH-1:0] frame_d [0:FRAME-1];
  logic                   done_rise;

  // Next-state, counters, capture and output decode; outputs depend only on
  // registered state so m_ready never reaches m_valid combinationally
  always_comb begin
    state_d       = state_q;
    done_prev_d   = done_in;
    idx_d         = idx_q;
    row_d         = row_q;
    col_d         = col_q;
    drop_d        = drop_q;
    frame_d       = frame_q;
    done_rise     = done_in & ~done_prev_q;

    m_valid       = 1'b0;
    capture_ready = 1'b0;
    m_data        = '0;
    m_row         = row_q;
    m_col         = col_q;
    m_eol         = 1'b0;
    m_last        = 1'b0;
    drop_count    = drop_q;

    case (state_q)
      SER_IDLE: begin
        capture_ready = 1'b1;
        if (done_rise) begin
          // Whole frame is snapshotted here; image_in is ignored afterwards
          frame_d = image_in;
          idx_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = SER_STREAM;
        end
      end

      SER_STREAM: begin
        m_valid = 1'b1;
        m_data  = frame_q[idx_q];
        m_eol   = (col_q == LAST_COL);
        m_last  = (idx_q == LAST_IDX);

        // A new frame while busy is lost, including on the final handshake
        if (done_rise && (drop_q != DROP_MAX)) begin
          drop_d = drop_q + 8'd1;
        end

        if (m_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = SER_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_d = '0;
              row_d = row_q + 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = SER_IDLE;
      end
    endcase
  end

  // Control registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= SER_IDLE;
      done_prev_q <= 1'b0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      done_prev_q <= done_prev_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drop_q      <= drop_d;
    end
  end

  // Frame buffer; contents are only meaningful while streaming, so no reset
  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

endmodule : deconv_out_serializer
`default_nettype wire

// File: tb/tb_deconv_out_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_deconv_out_serializer
// Description : Self-checking bench for deconv_out_serializer. Expected beats
//               come from a snapshot of the frame taken when done_in is
//               raised, with coordinates/flags derived from the beat number.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deconv_out_serializer;
  import deconv_pkg::*;

  localparam int N  = DEFAULT_N;
  localparam int K  = DEFAULT_K;
  localparam int PW = DEFAULT_PIXEL_WIDTH;
  localparam int OD = N * K;
  localparam int FS = OD * OD;
  localparam int CW = $clog2(OD);

  logic          clk;
  logic          rst;
  logic          done_in;
  logic [PW-1:0] image_in [0:FS-1];
  logic          m_valid;
  logic          m_ready;
  logic [PW-1:0] m_data;
  logic [CW-1:0] m_row;
  logic [CW-1:0] m_col;
  logic          m_eol;
  logic          m_last;
  logic          capture_ready;
  logic [7:0]    drop_count;

  int            n_checks  = 0;
  int            n_errors  = 0;
  int            exp_drops = 0;
  int            hold_left = 0;
  int            beat_sum  = 0;
  int            first_data = 0;
  logic [PW-1:0] exp_frame [0:FS-1];

  deconv_out_serializer #(
    .N           (N),
    .K           (K),
    .PIXEL_WIDTH (PW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .done_in       (done_in),
    .image_in      (image_in),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_row         (m_row),
    .m_col         (m_col),
    .m_eol         (m_eol),
    .m_last        (m_last),
    .capture_ready (capture_ready),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded loops
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; releases a done_in pulse when due
  task automatic tick();
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) done_in = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      check("idle_valid", m_valid, 1'b0);
      check("idle_cap_ready", capture_ready, 1'b1);
      tick();
    end
  endtask

  task automatic load_ramp();
    foreach (image_in[i]) image_in[i] = PW'(i);
  endtask

  task automatic load_random();
    foreach (image_in[i]) image_in[i] = PW'($urandom);
  endtask

  // Raise done_in for 'hold' cycles; the frame present now is the expected one
  task automatic fire_done(input int hold, input bit scramble);
    exp_frame = image_in;
    done_in   = 1'b1;
    hold_left = hold;
    tick();
    check("cap_valid", m_valid, 1'b1);
    check("cap_ready_low", capture_ready, 1'b0);
    if (scramble) foreach (image_in[i]) image_in[i] = '1;
  endtask

  // Drain one frame. mode 0: ready always, 1: 1,0,0 pattern, 2: random.
  task automatic stream(input int mode, input int drop_beat, input bit drop_last,
                        input int rst_beat);
    int beat = 0;
    int cyc  = 0;
    bit dropped = 1'b0;
    beat_sum = 0;
    while (beat < FS) begin
      if (cyc > 4000) begin
        check("stream_timeout", beat, FS);
        m_ready = 1'b0;
        return;
      end
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 3 == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      check("valid", m_valid, 1'b1);
      check("data", m_data, exp_frame[beat]);
      check("row", m_row, beat / OD);
      check("col", m_col, beat % OD);
      check("eol", m_eol, (beat % OD) == OD - 1);
      check("last", m_last, beat == FS - 1);
      if (beat == rst_beat) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_ready = 1'b0;
        exp_drops = 0;
        check("rst_valid", m_valid, 1'b0);
        check("rst_cap_ready", capture_ready, 1'b1);
        check("rst_drops", drop_count, 0);
        check("rst_last", m_last, 1'b0);
        check("rst_data", m_data, 0);
        check("rst_row", m_row, 0);
        check("rst_col", m_col, 0);
        return;
      end
      if (!dropped && beat == drop_beat) begin
        done_in   = 1'b1;
        hold_left = 1;
        dropped   = 1'b1;
        exp_drops++;
      end
      if (drop_last && beat == FS - 1 && m_ready) begin
        done_in   = 1'b1;
        hold_left = 1;
        exp_drops++;
      end
      if (m_ready) begin
        if (beat == 0) first_data = int'(m_data);
        beat_sum += int'(m_data);
        beat++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    check("end_valid", m_valid, 1'b0);
    check("end_cap_ready", capture_ready, 1'b1);
    check("end_last", m_last, 1'b0);
    if (mode == 0) check("frame_cycles", cyc, FS);
  endtask

  initial begin
    int ref_sum;
    rst     = 1'b0;
    done_in = 1'b0;
    m_ready = 1'b0;
    load_ramp();
    repeat (3) tick();
    check("reset_valid", m_valid, 1'b0);
    check("reset_cap_ready", capture_ready, 1'b1);
    check("reset_drops", drop_count, 0);
    check("reset_eol", m_eol, 1'b0);
    check("reset_last", m_last, 1'b0);
    check("reset_data", m_data, 0);
    check("reset_row", m_row, 0);
    check("reset_col", m_col, 0);
    rst = 1'b1;
    tick();
    idle(2);

    // Ramp frame, full throughput
    fire_done(1, 1'b0);
    stream(0, -1, 1'b0, -1);
    idle(2);

    // Backpressure
    fire_done(1, 1'b0);
    stream(1, -1, 1'b0, -1);
    idle(2);

    // done_in held long, image_in overwritten after capture
    fire_done(50, 1'b1);
    stream(0, -1, 1'b0, -1);
    idle(20);
    check("held_drops", drop_count, 0);

    // Drops at beat 10 and on the final handshake
    load_ramp();
    fire_done(1, 1'b0);
    stream(0, 10, 1'b1, -1);
    idle(3);
    check("drop_count", drop_count, exp_drops);

    // Reset mid-frame, then capture with done_in already high at release
    fire_done(1, 1'b0);
    stream(0, -1, 1'b0, 20);
    load_random();
    exp_frame = image_in;
    done_in   = 1'b1;
    rst       = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_release_capture", m_valid, 1'b1);
    done_in = 1'b0;
    stream(0, -1, 1'b0, -1);
    idle(2);

    // Random frames with random backpressure
    for (int f = 0; f < 3; f++) begin
      load_random();
      fire_done(1, f == 1);
      stream(2, -1, 1'b0, -1);
      idle(1 + int'($urandom_range(0, 3)));
    end

    // deconv2D output for image [1 2;3 4], identity kernel, stride K
    ref_sum = 0;
    for (int r = 0; r < OD; r++) begin
      for (int c = 0; c < OD; c++) begin
        int p;
        p = ((r % K) == (c % K)) ? (1 + (r / K) * N + (c / K)) : 0;
        image_in[r * OD + c] = PW'(p);
        ref_sum += p;
      end
    end
    fire_done(1, 1'b0);
    stream(0, -1, 1'b0, -1);
    check("int_first_beat", first_data, 1);
    check("int_sum", beat_sum, ref_sum);
    idle(2);
    check("drop_final", drop_count, exp_drops);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_deconv_out_serializer
`default_nettype wire
